jailbreak_hs_sequencer: RTL and testbench
=========================================

Name: jailbreak_hs_sequencer

Overview:
- Sits in the jb_core_clk domain between the high-score CDC FIFO output and the Jailbreak core's shared work RAM.
- Accepts one byte request at a time and waits until the CPU side is idle.
- Takes ownership of the RAM port, performs the write or the read, and returns read data with a one-cycle valid pulse.
- Decodes the 0x53-byte high-score window into the two RAM ranges.

Parameters:
- READ_LATENCY, 2, RAM cycles from address presentation to valid hs_data_out; legal range 1..7.
- GUARD_CYCLES, 1, idle cycles with ownership released before the next request is accepted; legal range 0..3.

Ports:
- jb_core_clk  in  1  core clock; all logic is synchronous to its rising edge.
- reset_n  in  1  reset, asynchronous assert, active-low.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted on a cycle where req_valid and req_ready are both 1.
- req_address  in  7  window byte offset, 0x00..0x7F.
- req_data  in  8  write data.
- req_is_write  in  1  1 = write, 0 = read.
- cpu_busy  in  1  core needs the RAM port this cycle.
- hs_address  out  12  RAM address.
- hs_access_write  out  1  1 = this block owns the RAM port (core-side mux select).
- hs_write_enable  out  1  RAM write strobe.
- hs_data_in  out  8  RAM write data.
- hs_data_out  in  8  RAM read data.
- rsp_valid  out  1  one-cycle pulse; rsp_data is valid while it is high.
- rsp_data  out  8  read result.
- err_unmapped  out  1  one-cycle pulse on an access to offset 0x53..0x7F.

Behaviour:
- Reset (reset_n = 0, asynchronous): FSM goes to IDLE; every output is 0; any latched request is discarded; the guard counter is cleared.
- Address decode, combinational on the latched offset a:
  - a 0x00..0x4F -> 0x620 + a.
  - a 0x50..0x52 -> 0x57E + (a - 0x50).
  - otherwise unmapped.
- Request acceptance:
  - req_ready = 1 only in IDLE.
  - On handshake, latch address, data and is_write.
- States:
  - IDLE: on handshake, an unmapped request goes to UNMAPPED; a mapped request goes to WAIT_GRANT.
  - UNMAPPED (1 cycle): err_unmapped = 1. A read also drives rsp_valid = 1 with rsp_data = 0x00. A write is dropped. hs_access_write stays 0. Next state is GUARD.
  - WAIT_GRANT: hs_access_write = 0. When cpu_busy is sampled 0, go to ACCESS next cycle; otherwise stay, with no timeout.
  - ACCESS (cycle N): hs_access_write = 1; hs_address and hs_data_in driven from the latch; hs_write_enable = is_write for this single cycle only. A write goes to RELEASE; a read goes to READ_WAIT.
  - READ_WAIT: cycles N+1..N+READ_LATENCY. hs_access_write = 1, hs_address held, hs_write_enable = 0. hs_data_out is captured into rsp_data at the edge ending cycle N+READ_LATENCY. Next state is RELEASE.
  - RELEASE (1 cycle): hs_access_write = 0. After a read, rsp_valid = 1 with the captured rsp_data. Next state is GUARD.
  - GUARD: stay GUARD_CYCLES cycles, then IDLE; with GUARD_CYCLES = 0, go straight to IDLE.
- Ownership rule: once in ACCESS, the port is held through READ_WAIT. cpu_busy rising during this time is ignored; the core side must stall on hs_access_write.
- Address and data hold: hs_address and hs_data_in keep their last values outside ownership (don't-care to the RAM); they reset to 0.
- rsp_data keeps its last value between pulses.
- Back-to-back requests: no new request is accepted until IDLE. Minimum spacing between accepted mapped writes is 4 + GUARD_CYCLES cycles with cpu_busy = 0.
- cpu_busy toggling inside WAIT_GRANT: the grant uses only the current-cycle sample.

Test Plan:
- Mapped write: write a = 0x00, data 0xA5, cpu_busy = 0, accepted cycle 0.
  -> Cycle 2: hs_access_write = 1, hs_address = 0x620, hs_write_enable = 1, hs_data_in = 0xA5. Cycle 3: ownership dropped. No rsp_valid. req_ready = 1 again at cycle 5.
- Second-range read: read a = 0x51, READ_LATENCY = 2, RAM model returns 0x3C, accepted cycle 0.
  -> hs_address = 0x57F and hs_access_write = 1 in cycles 2..4. rsp_valid = 1 with rsp_data = 0x3C in cycle 5 only. hs_write_enable is never 1.
- Unmapped accesses: read a = 0x60.
  -> Cycle 1: err_unmapped = 1, rsp_valid = 1, rsp_data = 0x00; hs_access_write stays 0.
  -> Write a = 0x7F: err_unmapped pulse, no rsp_valid, no RAM activity.
- CPU contention: cpu_busy held 1 for 10 cycles after a write to a = 0x4F is accepted.
  -> hs_access_write stays 0 throughout. ACCESS at 0x66F occurs one cycle after the first cpu_busy = 0 sample. Raising cpu_busy during a READ_WAIT does not drop hs_access_write.
- Reset mid-operation: reset_n pulsed low during READ_WAIT.
  -> All outputs 0 immediately, with no clock edge required. No rsp_valid after release. req_ready = 1 on the first cycle after reset deasserts.
- Back-to-back requests: two requests presented with req_valid held 1.
  -> Second request accepted only after GUARD completes; req_ready = 0 from acceptance through GUARD.

Source files
------------

// File: rtl/jailbreak_hs_sequencer_if.sv
// jailbreak_hs_sequencer_if: request/response handshake and work-RAM port of the high-score sequencer
interface jailbreak_hs_sequencer_if;
  logic        req_valid;
  logic        req_ready;
  logic [6:0]  req_address;
  logic [7:0]  req_data;
  logic        req_is_write;
  logic        cpu_busy;
  logic [11:0] hs_address;
  logic        hs_access_write;
  logic        hs_write_enable;
  logic [7:0]  hs_data_in;
  logic [7:0]  hs_data_out;
  logic        rsp_valid;
  logic [7:0]  rsp_data;
  logic        err_unmapped;
  modport master (
    output req_valid, req_address, req_data, req_is_write, cpu_busy, hs_data_out,
    input  req_ready, hs_address, hs_access_write, hs_write_enable, hs_data_in,
           rsp_valid, rsp_data, err_unmapped
  );
  modport slave (
    input  req_valid, req_address, req_data, req_is_write, cpu_busy, hs_data_out,
    output req_ready, hs_address, hs_access_write, hs_write_enable, hs_data_in,
           rsp_valid, rsp_data, err_unmapped
  );
endinterface

// File: rtl/jailbreak_hs_sequencer.sv
// jailbreak_hs_sequencer: serialises high-score byte requests onto the Jailbreak core's shared work RAM
module jailbreak_hs_sequencer #(
  parameter int READ_LATENCY = 2,
  parameter int GUARD_CYCLES = 1
) (
  input logic                     jb_core_clk,
  input logic                     reset_n,
  jailbreak_hs_sequencer_if.slave bus
);
  typedef enum logic [2:0] {IDLE, UNMAPPED, WAIT_GRANT, ACCESS, READ_WAIT, RELEASE, GUARD} state_t;
  state_t      st, nxt;
  logic [6:0]  lat_addr;
  logic [7:0]  lat_data;
  logic        lat_wr;
  logic [2:0]  cnt;
  logic        fire, mapped_req;
  logic [11:0] ram_addr;
  state_t      after_rel;
  assign fire       = bus.req_valid && bus.req_ready;
  assign mapped_req = bus.req_address < 7'h53;
  assign ram_addr   = lat_addr < 7'h50 ? 12'h620 + 12'(lat_addr) : 12'h57E + 12'(lat_addr - 7'h50);
  assign after_rel  = GUARD_CYCLES == 0 ? IDLE : GUARD;
  assign bus.req_ready       = reset_n && st == IDLE;
  assign bus.hs_access_write = st == ACCESS || st == READ_WAIT;
  assign bus.hs_write_enable = st == ACCESS && lat_wr;
  assign bus.err_unmapped    = st == UNMAPPED;
  assign bus.rsp_valid       = (st == UNMAPPED || st == RELEASE) && !lat_wr;
  always_comb begin
    nxt = st;
    case (st)
      IDLE:              nxt = !fire ? IDLE : mapped_req ? WAIT_GRANT : UNMAPPED;
      UNMAPPED, RELEASE: nxt = after_rel;
      WAIT_GRANT:        nxt = bus.cpu_busy ? WAIT_GRANT : ACCESS;
      ACCESS:            nxt = lat_wr ? RELEASE : READ_WAIT;
      READ_WAIT:         nxt = cnt == 3'd0 ? RELEASE : READ_WAIT;
      GUARD:             nxt = cnt == 3'd0 ? IDLE : GUARD;
      default:           nxt = IDLE;
    endcase
  end
  always_ff @(posedge jb_core_clk or negedge reset_n) begin
    if (!reset_n) begin
      st             <= IDLE;
      lat_addr       <= '0;
      lat_data       <= '0;
      lat_wr         <= 1'b0;
      cnt            <= '0;
      bus.hs_address <= '0;
      bus.hs_data_in <= '0;
      bus.rsp_data   <= '0;
    end else begin
      st <= nxt;
      if (fire) begin
        lat_addr <= bus.req_address;
        lat_data <= bus.req_data;
        lat_wr   <= bus.req_is_write;
        if (!mapped_req && !bus.req_is_write) bus.rsp_data <= 8'h00;
      end
      if (st == WAIT_GRANT && nxt == ACCESS) begin
        bus.hs_address <= ram_addr;
        bus.hs_data_in <= lat_data;
      end
      cnt <= nxt == READ_WAIT && st != READ_WAIT ? 3'(READ_LATENCY - 1) :
             nxt == GUARD && st != GUARD         ? 3'(GUARD_CYCLES - 1) :
                                                   cnt - {2'b0, |cnt};
      if (st == READ_WAIT && cnt == 3'd0) bus.rsp_data <= bus.hs_data_out;
    end
  end
endmodule

// File: tb/tb_jailbreak_hs_sequencer.sv
// tb_jailbreak_hs_sequencer: transaction-level schedule model compared against the DUT every cycle
module tb_jailbreak_hs_sequencer;
  localparam int RL   = 2;
  localparam int G    = 1;
  localparam int MAXN = 1024;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  bit cmp_on = 1'b0;
  jailbreak_hs_sequencer_if bus();
  jailbreak_hs_sequencer #(.READ_LATENCY(RL), .GUARD_CYCLES(G)) dut (
    .jb_core_clk(clk),
    .reset_n(reset_n),
    .bus(bus.slave)
  );
  always #5 clk = ~clk;
  bit         busy[MAXN], rv[MAXN], rw[MAXN];
  logic [6:0] ra[MAXN];
  logic [7:0] rd[MAXN], dout[MAXN];
  bit          e_ready[MAXN], e_aw[MAXN], e_we[MAXN], e_rv[MAXN], e_err[MAXN];
  logic [11:0] e_addr[MAXN];
  logic [7:0]  e_din[MAXN], e_rdata[MAXN];
  bit          a_set[MAXN], r_set[MAXN];
  logic [11:0] a_val[MAXN];
  logic [7:0]  d_val[MAXN], r_val[MAXN];
  task automatic chk(input string nm, input int c, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s cycle %0d: got %0h, expected %0h", nm, c, act, exp);
    end
  endtask
  function automatic logic [11:0] ram_of(input int a);
    return 12'(a < 80 ? 1568 + a : 1406 + a - 80);
  endfunction
  task automatic clear_stim();
    for (int i = 0; i < MAXN; i++) begin
      busy[i] = 0; rv[i] = 0; rw[i] = 0; ra[i] = '0; rd[i] = '0; dout[i] = '0;
    end
  endtask
  // Schedule each accepted request as a whole transaction, then expand into per-cycle expectations.
  task automatic build(input int L);
    int c, g, acc;
    for (int i = 0; i < MAXN; i++) begin
      e_ready[i] = 0; e_aw[i] = 0; e_we[i] = 0; e_rv[i] = 0; e_err[i] = 0;
      a_set[i] = 0; r_set[i] = 0; a_val[i] = '0; d_val[i] = '0; r_val[i] = '0;
    end
    c = 0;
    while (c < L) begin
      e_ready[c] = 1;
      if (!rv[c]) begin
        c++;
        continue;
      end
      if (ra[c] >= 7'h53) begin
        e_err[c+1] = 1;
        if (!rw[c]) begin
          e_rv[c+1] = 1; r_set[c+1] = 1; r_val[c+1] = 8'h00;
        end
        c = c + 2 + G;
      end else begin
        g = c + 1;
        while (busy[g]) g++;
        acc = g + 1;
        e_aw[acc] = 1; e_we[acc] = rw[c];
        a_set[acc] = 1; a_val[acc] = ram_of(int'(ra[c])); d_val[acc] = rd[c];
        if (rw[c]) c = acc + 2 + G;
        else begin
          for (int k = 1; k <= RL; k++) e_aw[acc+k] = 1;
          e_rv[acc+RL+1] = 1; r_set[acc+RL+1] = 1; r_val[acc+RL+1] = dout[acc+RL];
          c = acc + RL + 2 + G;
        end
      end
    end
    for (int i = 0; i < L; i++) begin
      e_addr[i]  = a_set[i] ? a_val[i] : (i == 0 ? 12'h0 : e_addr[i-1]);
      e_din[i]   = a_set[i] ? d_val[i] : (i == 0 ? 8'h0 : e_din[i-1]);
      e_rdata[i] = r_set[i] ? r_val[i] : (i == 0 ? 8'h0 : e_rdata[i-1]);
    end
  endtask
  task automatic drive_idle();
    bus.req_valid = 0; bus.req_address = '0; bus.req_data = '0; bus.req_is_write = 0;
    bus.cpu_busy = 0; bus.hs_data_out = '0;
  endtask
  task automatic run_seg(input int L);
    build(L);
    cmp_on = 0;
    reset_n = 0;
    drive_idle();
    repeat (2) @(posedge clk);
    @(negedge clk) reset_n = 1;
    for (int c = 0; c < L; c++) begin
      @(posedge clk);
      #1;
      cyc = c;
      bus.req_valid = rv[c]; bus.req_address = ra[c]; bus.req_data = rd[c];
      bus.req_is_write = rw[c]; bus.cpu_busy = busy[c]; bus.hs_data_out = dout[c];
      cmp_on = 1;
    end
    @(posedge clk);
    #1;
    cmp_on = 0;
    drive_idle();
  endtask
  always @(negedge clk) begin
    if (cmp_on) begin
      chk("req_ready", cyc, 32'(bus.req_ready), 32'(e_ready[cyc]));
      chk("hs_access_write", cyc, 32'(bus.hs_access_write), 32'(e_aw[cyc]));
      chk("hs_write_enable", cyc, 32'(bus.hs_write_enable), 32'(e_we[cyc]));
      chk("hs_address", cyc, 32'(bus.hs_address), 32'(e_addr[cyc]));
      chk("hs_data_in", cyc, 32'(bus.hs_data_in), 32'(e_din[cyc]));
      chk("rsp_valid", cyc, 32'(bus.rsp_valid), 32'(e_rv[cyc]));
      chk("rsp_data", cyc, 32'(bus.rsp_data), 32'(e_rdata[cyc]));
      chk("err_unmapped", cyc, 32'(bus.err_unmapped), 32'(e_err[cyc]));
    end
  end
  task automatic chk_all_zero(input string nm);
    chk({nm, " req_ready"}, -1, 32'(bus.req_ready), 0);
    chk({nm, " hs_address"}, -1, 32'(bus.hs_address), 0);
    chk({nm, " hs_access_write"}, -1, 32'(bus.hs_access_write), 0);
    chk({nm, " hs_write_enable"}, -1, 32'(bus.hs_write_enable), 0);
    chk({nm, " hs_data_in"}, -1, 32'(bus.hs_data_in), 0);
    chk({nm, " rsp_valid"}, -1, 32'(bus.rsp_valid), 0);
    chk({nm, " rsp_data"}, -1, 32'(bus.rsp_data), 0);
    chk({nm, " err_unmapped"}, -1, 32'(bus.err_unmapped), 0);
  endtask
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, %0d vectors applied", vectors);
    $fatal(1, "watchdog");
  end
  initial begin
    drive_idle();
    repeat (2) @(posedge clk);
    #1 chk_all_zero("reset");
    // mapped write to offset 0x00
    clear_stim();
    rv[0] = 1; ra[0] = 7'h00; rd[0] = 8'hA5; rw[0] = 1;
    run_seg(10);
    chk("pin wr aw@2", 2, 32'(e_aw[2]), 1);
    chk("pin wr addr@2", 2, 32'(e_addr[2]), 32'h620);
    chk("pin wr we@2", 2, 32'(e_we[2]), 1);
    chk("pin wr din@2", 2, 32'(e_din[2]), 32'hA5);
    chk("pin wr aw@3", 3, 32'(e_aw[3]), 0);
    chk("pin wr ready@4", 4, 32'(e_ready[4]), 0);
    chk("pin wr ready@5", 5, 32'(e_ready[5]), 1);
    // second-range read at 0x51
    clear_stim();
    rv[0] = 1; ra[0] = 7'h51;
    for (int i = 0; i < 12; i++) dout[i] = 8'h3C;
    run_seg(12);
    chk("pin rd addr@2", 2, 32'(e_addr[2]), 32'h57F);
    chk("pin rd addr@4", 4, 32'(e_addr[4]), 32'h57F);
    chk("pin rd aw@4", 4, 32'(e_aw[4]), 1);
    chk("pin rd aw@5", 5, 32'(e_aw[5]), 0);
    chk("pin rd rv@5", 5, 32'(e_rv[5]), 1);
    chk("pin rd data@5", 5, 32'(e_rdata[5]), 32'h3C);
    chk("pin rd rv@6", 6, 32'(e_rv[6]), 0);
    // unmapped read clears rsp_data; unmapped write only flags
    clear_stim();
    rv[0] = 1; ra[0] = 7'h10;
    rv[7] = 1; ra[7] = 7'h60;
    rv[10] = 1; ra[10] = 7'h7F; rw[10] = 1; rd[10] = 8'hEE;
    for (int i = 0; i < 16; i++) dout[i] = 8'h3C;
    run_seg(16);
    chk("pin um rdata@5", 5, 32'(e_rdata[5]), 32'h3C);
    chk("pin um err@8", 8, 32'(e_err[8]), 1);
    chk("pin um rv@8", 8, 32'(e_rv[8]), 1);
    chk("pin um rdata@8", 8, 32'(e_rdata[8]), 0);
    chk("pin um aw@8", 8, 32'(e_aw[8]), 0);
    chk("pin um err@11", 11, 32'(e_err[11]), 1);
    chk("pin um rv@11", 11, 32'(e_rv[11]), 0);
    // cpu contention, then cpu_busy raised during READ_WAIT
    clear_stim();
    rv[0] = 1; ra[0] = 7'h4F; rw[0] = 1; rd[0] = 8'h11;
    for (int i = 1; i <= 10; i++) busy[i] = 1;
    rv[15] = 1; ra[15] = 7'h20;
    busy[18] = 1; busy[19] = 1;
    for (int i = 0; i < 26; i++) dout[i] = 8'(i * 7 + 3);
    run_seg(26);
    chk("pin busy aw@11", 11, 32'(e_aw[11]), 0);
    chk("pin busy aw@12", 12, 32'(e_aw[12]), 1);
    chk("pin busy addr@12", 12, 32'(e_addr[12]), 32'h66F);
    chk("pin busy aw@19", 19, 32'(e_aw[19]), 1);
    chk("pin busy rv@20", 20, 32'(e_rv[20]), 1);
    // back-to-back writes with req_valid held
    clear_stim();
    for (int i = 0; i < 15; i++) begin
      rv[i] = 1; ra[i] = 7'h05; rd[i] = 8'h42; rw[i] = 1;
    end
    run_seg(20);
    chk("pin b2b ready@1", 1, 32'(e_ready[1]), 0);
    chk("pin b2b ready@4", 4, 32'(e_ready[4]), 0);
    chk("pin b2b ready@5", 5, 32'(e_ready[5]), 1);
    chk("pin b2b aw@7", 7, 32'(e_aw[7]), 1);
    // randomized segments
    for (int s = 0; s < 3; s++) begin
      clear_stim();
      for (int c = 0; c < 500; c++) begin
        busy[c] = $urandom_range(99) < 35;
        rv[c]   = $urandom_range(99) < 60;
        rw[c]   = $urandom_range(1) == 1;
        rd[c]   = 8'($urandom);
        ra[c]   = $urandom_range(3) == 0 ? 7'($urandom_range(127, 80)) : 7'($urandom_range(79));
      end
      for (int c = 0; c < 530; c++) dout[c] = 8'($urandom);
      run_seg(530);
    end
    // asynchronous reset during READ_WAIT
    reset_n = 0;
    drive_idle();
    @(posedge clk);
    @(negedge clk) reset_n = 1;
    @(posedge clk);
    #1 bus.req_valid = 1; bus.req_address = 7'h30; bus.req_data = 8'h99; bus.hs_data_out = 8'h77;
    @(posedge clk);
    #1 bus.req_valid = 0;
    repeat (2) @(posedge clk);
    #1 chk("mid aw before reset", -1, 32'(bus.hs_access_write), 1);
    chk("mid addr before reset", -1, 32'(bus.hs_address), 32'h650);
    #1 reset_n = 0;
    #1 chk_all_zero("async reset");
    @(posedge clk);
    @(negedge clk) reset_n = 1;
    #1 chk("ready after reset", -1, 32'(bus.req_ready), 1);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("no rsp after reset", i, 32'(bus.rsp_valid), 0);
      chk("no own after reset", i, 32'(bus.hs_access_write), 0);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
